tensor_sweep_ctrl: RTL and testbench
====================================

Name: tensor_sweep_ctrl

Overview:
- Drives the tensor core's window-select interface and collects its slice outputs.
- Sweeps the 3x3 window origin over the feature tile, X inner (0..x_max), Y outer (0..y_max), issuing `cfg_reg` one position per cycle.
- Captures `tnsout` after a fixed core latency and buffers the 64-bit result vectors, tagged with position, into a small FIFO.
- Drains the FIFO on a valid/ready stream toward the output writer.

Parameters:
- CONFIG_WIDTH, 32, width of `cfg_reg` driven to the core.
- SLICE_CFG_WIDTH, 26, width of the per-slice config field in `cfg_reg[25:0]`.
- TENSOR_WIDTH, 8, bits per slice result.
- TENSOR_SLICE, 8, number of slices; result vector is TENSOR_WIDTH*TENSOR_SLICE = 64 bits.
- TC_LAT, 2, cycles from a `cfg_reg` change to the matching `tnsout`; must be >= 1.
- FIFO_DEPTH, 4, result FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  reset; asynchronous, active-low.
- start  input  1  one-cycle pulse that begins a sweep; ignored unless the block is idle.
- x_max  input  4  last X origin; values above 9 are treated as 9; sampled at start.
- y_max  input  2  last Y origin; sampled at start.
- slice_cfg  input  SLICE_CFG_WIDTH  slice config, sampled at start and held for the sweep.
- cfg_reg  output  CONFIG_WIDTH  to the core: {x[3:0], y[1:0], slice_cfg_latched}.
- tnsout  input  TENSOR_WIDTH*TENSOR_SLICE  slice results from the core.
- out_data  output  64  result vector at the FIFO head.
- out_x  output  4  X origin tag of the FIFO head.
- out_y  output  2  Y origin tag of the FIFO head.
- out_last  output  1  FIFO head is the final position of the sweep.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  downstream accepts.
- busy  output  1  high from the cycle after start until the last result is popped.
- done  output  1  one-cycle pulse in the cycle the last result is popped.

Behaviour:
- Reset (`rst`=0, async) clears:
  - `cfg_reg`, `busy`, `done`, `out_valid`, `out_last`, `out_data`, `out_x`, `out_y` to 0;
  - the FSM to IDLE;
  - the FIFO pointers and count, the in-flight pipeline and the latched config.
- Reset mid-sweep discards all results; nothing further is emitted.
- FSM states: IDLE, ISSUE, DRAIN.
  - IDLE: `cfg_reg` = {0,0,slice_cfg_latched}. On `start`, latch the clamped `x_max`, `y_max` and `slice_cfg`; set x=0, y=0; go to ISSUE.
  - ISSUE: each cycle with credit available, present the current (x,y) on `cfg_reg` and push a tag {x,y,last} into a TC_LAT-deep valid/tag shift pipeline. Then advance: if x<xm, x+1; else x=0 and y+1. When (x,y)=(xm,ym) is issued, go to DRAIN.
  - DRAIN: no new issues; `cfg_reg` holds the last position. Return to IDLE when the pipeline is empty, the FIFO is empty and the last entry has been popped; `done` pulses on that pop.
- Credit rule: issue only if fifo_count + inflight_count < FIFO_DEPTH, evaluated combinationally from the current-cycle counts, including a pop in the same cycle.
  - Without credit, `cfg_reg` holds its value and an invalid bubble enters the pipeline.
- Capture: when the valid bit exits the pipeline (TC_LAT cycles after issue), push {`tnsout`, tag} into the FIFO. Credit guarantees the FIFO is never full at push time.
- FIFO:
  - Simultaneous push and pop in the same cycle leaves the count unchanged.
  - Pop on `out_valid` & `out_ready`.
  - Output fields come from the head entry (registered storage, read combinationally).
  - Pointers wrap modulo FIFO_DEPTH.
- Single-position sweep (x_max=0, y_max=0): one issue, ISSUE goes to DRAIN directly, `out_last`=1 on the only entry.
- Total results per sweep = (xm+1)*(ym+1), emitted in issue order.
- `busy` remains high through DRAIN. A `start` arriving while `busy` has no effect.

Test Plan:
- Full sweep with x_max=9, y_max=3, out_ready=1 and a core model returning tnsout = {x,y} replicated: expect 40 results in order (0,0),(1,0)…(9,0),(0,1)…(9,3). `out_last` is set only on (9,3); `done` pulses once; throughput is one result per cycle after TC_LAT fill.
- Backpressure with x_max=5, y_max=0, out_ready=0: exactly 4 positions issued (x=0..3); `cfg_reg` X field holds at 4; `out_valid`=1. Then release out_ready: the remaining 2 positions complete and `done` pulses after the 6th pop.
- Clamp and degenerate cases: x_max=12, y_max=0 gives 10 results, last at x=9. x_max=0, y_max=0 gives 1 result with `out_last`=1, and `done` on its pop.
- Simultaneous events: with the FIFO at count 3, toggle out_ready so that push and pop coincide; the count stays 3, there is no loss or duplication, and order is preserved. A `start` pulsed during busy is ignored, so the result count is unchanged.
- Async reset: assert `rst`=0 mid-ISSUE at (3,1) between clock edges. All outputs go to 0 immediately. After release, a new start at x_max=1, y_max=0 yields exactly 2 fresh results.

Source files
------------

// File: rtl/tensor_sweep_ctrl.sv
// Sweeps the 3x3 window origin over the feature tile, drives the tensor core config
// and buffers position-tagged slice results in a credit-protected FIFO.
module tensor_sweep_ctrl #(
    parameter int CONFIG_WIDTH    = 32,
    parameter int SLICE_CFG_WIDTH = 26,
    parameter int TENSOR_WIDTH    = 8,
    parameter int TENSOR_SLICE    = 8,
    parameter int TC_LAT          = 2,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [3:0]                           x_max,
    input  logic [1:0]                           y_max,
    input  logic [SLICE_CFG_WIDTH-1:0]           slice_cfg,
    output logic [CONFIG_WIDTH-1:0]              cfg_reg,
    input  logic [TENSOR_WIDTH*TENSOR_SLICE-1:0] tnsout,
    output logic [TENSOR_WIDTH*TENSOR_SLICE-1:0] out_data,
    output logic [3:0]                           out_x,
    output logic [1:0]                           out_y,
    output logic                                 out_last,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic                                 busy,
    output logic                                 done
);

    localparam int RES_W = TENSOR_WIDTH * TENSOR_SLICE;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FC_W  = $clog2(FIFO_DEPTH + 1);
    localparam int CNT_W = $clog2(FIFO_DEPTH + TC_LAT + 1) + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    typedef struct packed {
        logic [3:0] x;
        logic [1:0] y;
        logic       last;
    } tag_t;

    typedef struct packed {
        logic [RES_W-1:0] data;
        tag_t             tag;
    } entry_t;

    state_t state, next_state;

    logic [3:0]                 x_cur, xm;
    logic [1:0]                 y_cur, ym;
    logic [SLICE_CFG_WIDTH-1:0] slice_lat;

    logic [TC_LAT-1:0] pipe_valid;
    tag_t              pipe_tag [TC_LAT];

    entry_t            mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [FC_W-1:0]   fifo_count;

    logic [CNT_W-1:0] inflight, committed;
    logic             credit, issue, is_last_pos, push, pop, drain_exit;
    entry_t           head;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < TC_LAT; i++) begin
            inflight = inflight + CNT_W'(pipe_valid[i]);
        end
    end

    // A pop in this cycle frees its slot immediately; a capture only moves an entry
    // from the pipeline into the FIFO, so it leaves the committed total unchanged.
    assign committed   = CNT_W'(fifo_count) + inflight - CNT_W'(pop);
    assign credit      = committed < CNT_W'(FIFO_DEPTH);
    assign issue       = (state == ISSUE) && credit;
    assign is_last_pos = (x_cur == xm) && (y_cur == ym);
    assign push        = pipe_valid[TC_LAT-1];
    assign pop         = out_valid && out_ready;
    assign drain_exit  = (state == DRAIN) && pop && out_last &&
                         (inflight == '0) && (fifo_count == FC_W'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = ISSUE;
            ISSUE:   if (issue && is_last_pos) next_state = DRAIN;
            DRAIN:   if (drain_exit) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = drain_exit;
        if (state == IDLE) begin
            cfg_reg = CONFIG_WIDTH'({4'd0, 2'd0, slice_lat});
        end else begin
            cfg_reg = CONFIG_WIDTH'({x_cur, y_cur, slice_lat});
        end
    end

    // The final position is not advanced past, so DRAIN keeps presenting it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_cur     <= '0;
            y_cur     <= '0;
            xm        <= '0;
            ym        <= '0;
            slice_lat <= '0;
        end else if (state == IDLE && start) begin
            xm        <= (x_max > 4'd9) ? 4'd9 : x_max;
            ym        <= y_max;
            slice_lat <= slice_cfg;
            x_cur     <= '0;
            y_cur     <= '0;
        end else if (issue && !is_last_pos) begin
            if (x_cur < xm) begin
                x_cur <= x_cur + 4'd1;
            end else begin
                x_cur <= '0;
                y_cur <= y_cur + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe_valid <= '0;
            for (int i = 0; i < TC_LAT; i++) begin
                pipe_tag[i] <= '0;
            end
        end else begin
            for (int i = TC_LAT - 1; i > 0; i--) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_tag[i]   <= pipe_tag[i-1];
            end
            pipe_valid[0] <= issue;
            pipe_tag[0]   <= '{x: x_cur, y: y_cur, last: is_last_pos};
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{data: tnsout, tag: pipe_tag[TC_LAT-1]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + FC_W'(1);
                2'b01:   fifo_count <= fifo_count - FC_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Head fields are gated so an empty FIFO presents all-zero outputs.
    assign head      = mem[rd_ptr];
    assign out_valid = (fifo_count != '0);
    assign out_data  = out_valid ? head.data     : '0;
    assign out_x     = out_valid ? head.tag.x    : '0;
    assign out_y     = out_valid ? head.tag.y    : '0;
    assign out_last  = out_valid ? head.tag.last : 1'b0;

endmodule

// File: tb/tb_tensor_sweep_ctrl.sv
// Self-checking bench for tensor_sweep_ctrl: table-driven sweeps plus directed
// backpressure and asynchronous reset sequences against a latency-matched core model.
module tb_tensor_sweep_ctrl;

   localparam int TC_LAT = 2;

   logic        clock;
   logic        rst;
   logic        start;
   logic [3:0]  x_max;
   logic [1:0]  y_max;
   logic [25:0] slice_cfg;
   logic [31:0] cfg_reg;
   logic [63:0] tnsout;
   logic [63:0] out_data;
   logic [3:0]  out_x;
   logic [1:0]  out_y;
   logic        out_last;
   logic        out_valid;
   logic        out_ready;
   logic        busy;
   logic        done;

   int checks;
   int failures;

   logic [31:0] corePipe [TC_LAT];

   typedef struct {
      logic [3:0]  xmax;
      logic [1:0]  ymax;
      logic [25:0] scfg;
      int          mode;
      logic [3:0]  expXm;
      logic [1:0]  expYm;
      int          expN;
      bit          chkTput;
      string       name;
   } vec_t;

   vec_t vecs [5];

   tensor_sweep_ctrl #(
      .CONFIG_WIDTH(32),
      .SLICE_CFG_WIDTH(26),
      .TENSOR_WIDTH(8),
      .TENSOR_SLICE(8),
      .TC_LAT(TC_LAT),
      .FIFO_DEPTH(4)
   ) dut (
      .clk(clock),
      .rst(rst),
      .start(start),
      .x_max(x_max),
      .y_max(y_max),
      .slice_cfg(slice_cfg),
      .cfg_reg(cfg_reg),
      .tnsout(tnsout),
      .out_data(out_data),
      .out_x(out_x),
      .out_y(out_y),
      .out_last(out_last),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .busy(busy),
      .done(done)
   );

   // 100 MHz clock
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Core model: tnsout reflects cfg_reg from TC_LAT cycles earlier, {x,y} in every slice
   always @(posedge clock) begin
      corePipe[0] <= cfg_reg;
      for (int i = 1; i < TC_LAT; i++) corePipe[i] <= corePipe[i-1];
   end
   assign tnsout = {8{2'b00, corePipe[TC_LAT-1][31:28], corePipe[TC_LAT-1][27:26]}};

   // Compare one value and report a failure line when it differs
   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
      end
   endtask

   // Pulse start with the given sweep parameters and check the first ISSUE cycle
   task automatic applyStimulus(input logic [3:0] xm, input logic [1:0] ym, input logic [25:0] scfg);
      @(negedge clock);
      x_max = xm;
      y_max = ym;
      slice_cfg = scfg;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      #1;
      checkOutput("busy_after_start", 64'(busy), 64'd1);
      checkOutput("cfg_first_issue", 64'(cfg_reg), 64'({4'd0, 2'd0, scfg}));
   endtask

   // Drain a sweep, scoring every popped entry against the expected raster order
   task automatic collectSweep(input logic [3:0] exm, input logic [1:0] eym, input int expN,
                               input int mode, input bit chkTput, input logic [25:0] scfg,
                               input string name);
      int npop = 0;
      int ndone = 0;
      int cyc = 0;
      int firstC = -1;
      int lastC = -1;
      bit doneOk = 0;
      bit stray = 0;
      logic [3:0] ex = 4'd0;
      logic [1:0] ey = 2'd0;
      while (npop < expN && cyc < 3000) begin
         @(negedge clock);
         cyc++;
         case (mode)
            1:       out_ready = cyc[0];
            2:       out_ready = (cyc % 3) != 0;
            default: out_ready = 1'b1;
         endcase
         if (mode == 1 && cyc == 5) begin
            start = 1'b1;
            x_max = 4'd2;
            y_max = 2'd0;
            slice_cfg = 26'h1234567;
         end else begin
            start = 1'b0;
         end
         #1;
         if (done) ndone++;
         if (out_valid && out_ready) begin
            checkOutput({name, "_x"}, 64'(out_x), 64'(ex));
            checkOutput({name, "_y"}, 64'(out_y), 64'(ey));
            checkOutput({name, "_data"}, out_data, {8{2'b00, ex, ey}});
            checkOutput({name, "_last"}, 64'(out_last), 64'(npop == expN - 1));
            if (done && npop == expN - 1) doneOk = 1;
            if (firstC < 0) firstC = cyc;
            lastC = cyc;
            npop++;
            if (ex < exm) ex = ex + 4'd1;
            else begin
               ex = 4'd0;
               ey = ey + 2'd1;
            end
         end
      end
      start = 1'b0;
      checkOutput({name, "_count"}, 64'(npop), 64'(expN));
      for (int k = 0; k < 4; k++) begin
         @(negedge clock);
         #1;
         if (done || out_valid) stray = 1;
      end
      checkOutput({name, "_no_extra"}, 64'(stray), 64'd0);
      checkOutput({name, "_done_once"}, 64'(ndone), 64'd1);
      checkOutput({name, "_done_on_last"}, 64'(doneOk), 64'd1);
      checkOutput({name, "_idle_busy"}, 64'(busy), 64'd0);
      checkOutput({name, "_idle_cfg"}, 64'(cfg_reg), 64'({6'd0, scfg}));
      if (chkTput) checkOutput({name, "_throughput"}, 64'(lastC - firstC), 64'(expN - 1));
   endtask

   initial begin
      int waitC;
      bit found;
      bit emitted;
      checks = 0;
      failures = 0;
      for (int i = 0; i < TC_LAT; i++) corePipe[i] = '0;
      rst = 1'b0;
      start = 1'b0;
      x_max = '0;
      y_max = '0;
      slice_cfg = '0;
      out_ready = 1'b0;

      vecs[0] = '{4'd9,  2'd3, 26'h2ABCDEF, 0, 4'd9, 2'd3, 40, 1'b1, "full"};
      vecs[1] = '{4'd12, 2'd0, 26'h0F0F0F0, 0, 4'd9, 2'd0, 10, 1'b1, "clamp"};
      vecs[2] = '{4'd0,  2'd0, 26'h3FFFFFF, 0, 4'd0, 2'd0, 1,  1'b0, "single"};
      vecs[3] = '{4'd3,  2'd1, 26'h1555555, 1, 4'd3, 2'd1, 8,  1'b0, "toggle"};
      vecs[4] = '{4'd0,  2'd3, 26'h0000ACE, 2, 4'd0, 2'd3, 4,  1'b0, "ycol"};

      #12;
      checkOutput("reset_cfg", 64'(cfg_reg), 64'd0);
      checkOutput("reset_valid", 64'(out_valid), 64'd0);
      checkOutput("reset_busy", 64'(busy), 64'd0);
      checkOutput("reset_done", 64'(done), 64'd0);
      checkOutput("reset_data", out_data, 64'd0);
      @(negedge clock);
      rst = 1'b1;

      for (int v = 0; v < 5; v++) begin
         applyStimulus(vecs[v].xmax, vecs[v].ymax, vecs[v].scfg);
         collectSweep(vecs[v].expXm, vecs[v].expYm, vecs[v].expN, vecs[v].mode,
                      vecs[v].chkTput, vecs[v].scfg, vecs[v].name);
      end

      // Backpressure: only four positions may be in flight or buffered
      out_ready = 1'b0;
      applyStimulus(4'd5, 2'd0, 26'h00BEEF0);
      repeat (10) @(negedge clock);
      #1;
      checkOutput("bp_valid", 64'(out_valid), 64'd1);
      checkOutput("bp_cfg_x", 64'(cfg_reg[31:28]), 64'd4);
      checkOutput("bp_cfg_y", 64'(cfg_reg[27:26]), 64'd0);
      checkOutput("bp_busy", 64'(busy), 64'd1);
      checkOutput("bp_head_x", 64'(out_x), 64'd0);
      collectSweep(4'd5, 2'd0, 6, 0, 1'b0, 26'h00BEEF0, "bp");

      // Asynchronous reset in the middle of ISSUE at (3,1)
      out_ready = 1'b1;
      applyStimulus(4'd9, 2'd3, 26'h2222222);
      found = 0;
      waitC = 0;
      while (!found && waitC < 200) begin
         @(negedge clock);
         #1;
         waitC++;
         if (cfg_reg[31:26] == {4'd3, 2'd1}) found = 1;
      end
      checkOutput("rst_reach_3_1", 64'(found), 64'd1);
      #2;
      rst = 1'b0;
      #1;
      checkOutput("rst_cfg", 64'(cfg_reg), 64'd0);
      checkOutput("rst_valid", 64'(out_valid), 64'd0);
      checkOutput("rst_busy", 64'(busy), 64'd0);
      checkOutput("rst_done", 64'(done), 64'd0);
      checkOutput("rst_head", {out_data[57:0], out_x, out_y}, 64'd0);
      checkOutput("rst_last", 64'(out_last), 64'd0);
      @(negedge clock);
      rst = 1'b1;
      emitted = 0;
      repeat (8) begin
         @(negedge clock);
         #1;
         if (out_valid || busy || done) emitted = 1;
      end
      checkOutput("rst_discard", 64'(emitted), 64'd0);
      applyStimulus(4'd1, 2'd0, 26'h0333333);
      collectSweep(4'd1, 2'd0, 2, 0, 1'b1, 26'h0333333, "post_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
